// File: rtl/vga_rect_draw_engine.sv
// Rectangle fill engine: clips a command to the frame and streams pixel writes in raster order.
// Latency: first pixel one edge after accept, one pixel per unstalled edge, Done one edge after the last pixel.
// Backpressure: Draw_Stall freezes the sweep; Cmd_Ready is low from accept until one cycle after Done.
// Optional outline-only mode is compiled in with VGA_RECT_OUTLINE_EN.
module vga_rect_draw_engine #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int COLOR_BITS = 9
) (
  input  logic                  Slow_Clock,
  input  logic                  Reset_N,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic [7:0]            Cmd_X,
  input  logic [6:0]            Cmd_Y,
  input  logic [7:0]            Cmd_W,
  input  logic [6:0]            Cmd_H,
  input  logic [COLOR_BITS-1:0] Cmd_Color,
  input  logic                  Cmd_Outline,
  input  logic                  Draw_Stall,
  output logic                  Enable_Draw,
  output logic [31:0]           Draw_X,
  output logic [31:0]           Draw_Y,
  output logic [31:0]           Draw_Color,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [8:0] X_LIM  = 9'(FB_WIDTH);
  localparam logic [8:0] Y_LIM  = 9'(FB_HEIGHT);
  localparam logic [8:0] X_LAST = 9'(FB_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(FB_HEIGHT - 1);

  logic [1:0]            state;
  logic [7:0]            xs_q, xe_q, cur_x;
  logic [6:0]            ye_q, cur_y;
  logic [COLOR_BITS-1:0] color_q;
  logic [7:0]            px_x_q;
  logic [6:0]            px_y_q;
  logic [COLOR_BITS-1:0] px_c_q;

`ifdef VGA_RECT_OUTLINE_EN
  logic                  outline_q;
  logic [6:0]            ys_q;
`else
  logic                  unused_outline;
  assign unused_outline = Cmd_Outline;
`endif

  logic [8:0] x_end_raw, y_end_raw;
  logic [7:0] x_end_clip;
  logic [6:0] y_end_clip;
  logic       cmd_empty;
  logic       row_end, last_pix, skip_in;
  logic [7:0] x_adv;

  // Clip the incoming command to the frame and flag rectangles with no visible pixels
  always_comb begin
    x_end_raw  = {1'b0, Cmd_X} + {1'b0, Cmd_W} - 9'd1;
    y_end_raw  = {2'b0, Cmd_Y} + {2'b0, Cmd_H} - 9'd1;
    x_end_clip = (x_end_raw > X_LAST) ? X_LAST[7:0] : x_end_raw[7:0];
    y_end_clip = (y_end_raw > Y_LAST) ? Y_LAST[6:0] : y_end_raw[6:0];
    cmd_empty  = (Cmd_W == 8'd0) || (Cmd_H == 7'd0) ||
                 ({1'b0, Cmd_X} >= X_LIM) || ({2'b0, Cmd_Y} >= Y_LIM);
  end

  // Sweep stepping: end-of-row / end-of-rectangle detection and the next column
  always_comb begin
    row_end  = (cur_x == xe_q);
    last_pix = row_end && (cur_y == ye_q);
`ifdef VGA_RECT_OUTLINE_EN
    // Interior rows of an outline only touch the two side columns
    skip_in  = outline_q && (cur_x == xs_q) && (cur_y != ys_q) && (cur_y != ye_q);
`else
    skip_in  = 1'b0;
`endif
    x_adv    = skip_in ? xe_q : cur_x + 8'd1;
  end

  // Command accept, raster sweep and completion handshake; Done is held in the first IDLE cycle
  always_ff @(posedge Slow_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state       <= IDLE;
      Cmd_Ready   <= 1'b1;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Enable_Draw <= 1'b0;
      xs_q        <= '0;
      xe_q        <= '0;
      ye_q        <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      color_q     <= '0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      px_c_q      <= '0;
`ifdef VGA_RECT_OUTLINE_EN
      outline_q   <= 1'b0;
      ys_q        <= '0;
`endif
    end else begin
      Enable_Draw <= 1'b0;
      case (state)
        IDLE: begin
          if (Done) begin
            Done      <= 1'b0;
            Busy      <= 1'b0;
            Cmd_Ready <= 1'b1;
          end else if (Cmd_Valid && Cmd_Ready) begin
            Cmd_Ready <= 1'b0;
            Busy      <= 1'b1;
            xs_q      <= Cmd_X;
            xe_q      <= x_end_clip;
            ye_q      <= y_end_clip;
            cur_x     <= Cmd_X;
            cur_y     <= Cmd_Y;
            color_q   <= Cmd_Color;
`ifdef VGA_RECT_OUTLINE_EN
            outline_q <= Cmd_Outline;
            ys_q      <= Cmd_Y;
`endif
            state     <= cmd_empty ? DONE : DRAW;
          end
        end
        DRAW: begin
          if (!Draw_Stall) begin
            Enable_Draw <= 1'b1;
            px_x_q      <= cur_x;
            px_y_q      <= cur_y;
            px_c_q      <= color_q;
            if (last_pix) begin
              state <= DONE;
            end else if (row_end) begin
              cur_x <= xs_q;
              cur_y <= cur_y + 7'd1;
            end else begin
              cur_x <= x_adv;
            end
          end
        end
        DONE: begin
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Draw_X     = {24'd0, px_x_q};
  assign Draw_Y     = {25'd0, px_y_q};
  assign Draw_Color = {{(32 - COLOR_BITS){1'b0}}, px_c_q};

endmodule

// File: tb/tb_vga_rect_draw_engine.sv
// Self-checking bench for vga_rect_draw_engine: directed cases plus randomized commands
// with random back-pressure; a scoreboard queue holds the expected pixel stream.
module tb_vga_rect_draw_engine;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int CB = 9;

  logic          Slow_Clock, Reset_N, Cmd_Valid, Cmd_Ready;
  logic [7:0]    Cmd_X, Cmd_W;
  logic [6:0]    Cmd_Y, Cmd_H;
  logic [CB-1:0] Cmd_Color;
  logic          Cmd_Outline, Draw_Stall, Enable_Draw, Busy, Done;
  logic [31:0]   Draw_X, Draw_Y, Draw_Color;

  vga_rect_draw_engine #(.FB_WIDTH(W), .FB_HEIGHT(H), .COLOR_BITS(CB)) dut (
    .Slow_Clock (Slow_Clock), .Reset_N (Reset_N),
    .Cmd_Valid  (Cmd_Valid),  .Cmd_Ready (Cmd_Ready),
    .Cmd_X      (Cmd_X),      .Cmd_Y (Cmd_Y), .Cmd_W (Cmd_W), .Cmd_H (Cmd_H),
    .Cmd_Color  (Cmd_Color),  .Cmd_Outline (Cmd_Outline),
    .Draw_Stall (Draw_Stall), .Enable_Draw (Enable_Draw),
    .Draw_X     (Draw_X),     .Draw_Y (Draw_Y), .Draw_Color (Draw_Color),
    .Busy       (Busy),       .Done (Done)
  );

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];

  int  checks = 0;
  int  errors = 0;
  int  pix_seen = 0;
  bit  stall_rand = 0;
  bit  stall_force = 0;

  initial begin
    Slow_Clock = 0;
    forever #5 Slow_Clock = ~Slow_Clock;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enumerate the visible (and, in outline mode, border) pixels of a command
  task automatic model_push(input int x, input int y, input int w, input int h,
                            input int c, input bit o, output int n);
    int xe, ye;
    bit outl;
    n = 0;
`ifdef VGA_RECT_OUTLINE_EN
    outl = o;
`else
    outl = 0;
`endif
    if (w == 0 || h == 0 || x >= W || y >= H) return;
    xe = (x + w - 1 > W - 1) ? W - 1 : x + w - 1;
    ye = (y + h - 1 > H - 1) ? H - 1 : y + h - 1;
    for (int yy = y; yy <= ye; yy++)
      for (int xx = x; xx <= xe; xx++)
        if (!outl || yy == y || yy == ye || xx == x || xx == xe) begin
          pix_t p;
          p.x = xx; p.y = yy; p.c = c;
          exp_q.push_back(p);
          n++;
        end
  endtask

  // Stall driver: random back-pressure or a directed level
  always @(posedge Slow_Clock) begin
    #1;
    Draw_Stall = stall_rand ? ($urandom_range(0, 3) == 0) : stall_force;
  end

  // Monitor: every pixel write is popped from the scoreboard and compared
  always @(negedge Slow_Clock) begin
    if (Enable_Draw) begin
      pix_seen++;
      chk(Draw_X < W && Draw_Y < H, "pix_in_frame", Draw_X * 1000 + Draw_Y, -1);
      chk(exp_q.size() != 0, "pix_expected", 0, 1);
      if (exp_q.size() != 0) begin
        pix_t p;
        p = exp_q.pop_front();
        chk(Draw_X == 32'(p.x), "pix_x", Draw_X, p.x);
        chk(Draw_Y == 32'(p.y), "pix_y", Draw_Y, p.y);
        chk(Draw_Color == 32'(p.c), "pix_color", Draw_Color, p.c);
      end
    end
  end

  task automatic wait_ready(input string name);
    int i;
    @(negedge Slow_Clock);
    for (i = 0; i < 5000 && !Cmd_Ready; i++) @(negedge Slow_Clock);
    chk(Cmd_Ready == 1'b1, name, Cmd_Ready, 1);
  endtask

  // Present a command at a negedge with Cmd_Ready high; returns just after the accept edge
  task automatic issue(input int x, input int y, input int w, input int h,
                       input int c, input bit o, input bit keep, output int n);
    wait_ready("ready_before_cmd");
    Cmd_X = 8'(x); Cmd_Y = 7'(y); Cmd_W = 8'(w); Cmd_H = 7'(h);
    Cmd_Color = CB'(c); Cmd_Outline = o; Cmd_Valid = 1;
    model_push(x, y, w, h, c, o, n);
    @(posedge Slow_Clock);
    #1;
    if (!keep) Cmd_Valid = 0;
  endtask

  task automatic drain();
    wait_ready("ready_after_cmd");
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
  endtask

  // Unstalled cycle-exact handshake timing after an accept edge
  task automatic check_timing(input int n);
    @(negedge Slow_Clock);
    chk(Busy == 1 && Cmd_Ready == 0, "accept_busy_ready", {Busy, Cmd_Ready}, 2);
    for (int j = 1; j <= n; j++) begin
      @(negedge Slow_Clock);
      chk(Enable_Draw == 1 && Busy == 1, "pixel_consecutive", {Enable_Draw, Busy}, 3);
    end
    @(negedge Slow_Clock);
    chk(Done == 1 && Enable_Draw == 0 && Busy == 1 && Cmd_Ready == 0, "done_cycle",
        {Done, Enable_Draw, Busy, Cmd_Ready}, 4'b1010);
    @(negedge Slow_Clock);
    chk(Done == 0 && Busy == 0 && Cmd_Ready == 1, "ready_return", {Done, Busy, Cmd_Ready}, 3'b001);
  endtask

  task automatic check_reset_vals(input string name);
    chk(Cmd_Ready == 1 && Enable_Draw == 0 && Busy == 0 && Done == 0, name,
        {Cmd_Ready, Enable_Draw, Busy, Done}, 4'b1000);
    chk(Draw_X == 0 && Draw_Y == 0 && Draw_Color == 0, {name, "_draw"},
        Draw_X + Draw_Y + Draw_Color, 0);
  endtask

  initial begin
    int n, nb, base;
    Reset_N = 0; Cmd_Valid = 0; Cmd_X = 0; Cmd_Y = 0; Cmd_W = 0; Cmd_H = 0;
    Cmd_Color = 0; Cmd_Outline = 0; Draw_Stall = 0;
    repeat (3) @(negedge Slow_Clock);
    check_reset_vals("reset_state");
    Reset_N = 1;

    // Basic fill 3x2
    issue(10, 20, 3, 2, 9'h1FF, 0, 0, n);
    chk(n == 6, "model_count_basic", n, 6);
    check_timing(6);
    drain();

    // Clipped at the bottom-right corner, then fully off-frame
    issue(158, 119, 5, 4, 9'h0A5, 0, 0, n);
    check_timing(2);
    drain();
    issue(160, 0, 1, 1, 9'h033, 0, 0, n);
    check_timing(0);
    drain();

    // Zero width: Busy exactly two cycles
    issue(3, 3, 0, 5, 9'h111, 0, 0, n);
    check_timing(0);
    drain();

    // Directed stall of three cycles after the first pixel of a 2x2 at the origin
    issue(0, 0, 2, 2, 9'h155, 0, 0, n);
    @(negedge Slow_Clock);
    stall_force = 1;
    @(negedge Slow_Clock);
    chk(Enable_Draw == 1 && Draw_X == 0 && Draw_Y == 0, "stall_first_pix", Enable_Draw, 1);
    for (int j = 2; j <= 4; j++) begin
      @(negedge Slow_Clock);
      chk(Enable_Draw == 0, "stall_no_enable", Enable_Draw, 0);
      chk(Draw_X == 0 && Draw_Y == 0 && Draw_Color == 32'h155, "stall_hold",
          Draw_X * 1000 + Draw_Y, 0);
      if (j == 3) stall_force = 0;
    end
    base = pix_seen;
    drain();
    chk(pix_seen - base == 3, "stall_remaining", pix_seen - base, 3);

    // Outline request
    base = pix_seen;
    issue(5, 5, 4, 3, 9'h0F0, 1, 0, n);
    drain();
`ifdef VGA_RECT_OUTLINE_EN
    chk(pix_seen - base == 10, "outline_count", pix_seen - base, 10);
`else
    chk(pix_seen - base == 12, "outline_count", pix_seen - base, 12);
`endif

    // Cmd_Valid held through a command: second command waits for Cmd_Ready
    issue(30, 40, 4, 1, 9'h0C3, 0, 1, n);
    Cmd_X = 8'd50; Cmd_Y = 7'd60; Cmd_W = 8'd2; Cmd_H = 7'd2; Cmd_Color = 9'h13C;
    model_push(50, 60, 2, 2, 9'h13C, 0, nb);
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge Slow_Clock);
      chk(Cmd_Ready == 0, "held_valid_ready_low", Cmd_Ready, 0);
    end
    @(negedge Slow_Clock);
    chk(Cmd_Ready == 1, "held_valid_ready_back", Cmd_Ready, 1);
    @(posedge Slow_Clock);
    #1 Cmd_Valid = 0;
    drain();

    // Randomized commands with random back-pressure
    stall_rand = 1;
    for (int k = 0; k < 40; k++) begin
      int x, y, w, h;
      x = $urandom_range(0, 175);
      y = $urandom_range(0, 127);
      w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      issue(x, y, w, h, $urandom_range(0, 511), 1'($urandom_range(0, 1)), 0, n);
      drain();
    end
    stall_rand = 0;

    // Reset in the middle of a sweep
    issue(0, 0, 50, 10, 9'h1AA, 0, 0, n);
    repeat (5) @(negedge Slow_Clock);
    @(posedge Slow_Clock);
    #2 Reset_N = 0;
    #1 check_reset_vals("reset_mid_sweep");
    exp_q.delete();
    repeat (3) @(negedge Slow_Clock);
    Reset_N = 1;
    base = pix_seen;
    repeat (20) @(negedge Slow_Clock);
    #1;
    chk(pix_seen == base, "no_pix_after_reset", pix_seen - base, 0);
    check_reset_vals("idle_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
